sseg_scan_decoder: RTL and testbench

Receive-side counterpart of the clock's multiplexed seven-segment display drive. It samples the scanned `sseg`/`dgt` lines and waits for each digit strobe to settle. It then decodes each segment pattern back to BCD and publishes a complete four-digit frame (HH:MM) with error, change and staleness status. It is used as an in-system display monitor and as the self-checking front end of display-level benches.

---
 rtl/sseg_pkg.sv | 49 ++++
 rtl/sseg2bcd.sv | 31 +++
 rtl/sseg_scan_decoder.sv | 171 +++++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan decoder.
//   - Active-low segment codes ordered {g,f,e,d,c,b,a}
//   - Scan FSM state type
//   - Digit-select helpers (qualification and slot index)
package sseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] DIGIT_BAD = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

  // Exactly one digit strobe asserted (active low).
  function automatic logic dgt_qual(input logic [3:0] d);
    logic q;
    case (d)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: q = 1'b1;
      default:                            q = 1'b0;
    endcase
    return q;
  endfunction

  // Slot index of the asserted strobe; only meaningful when dgt_qual(d).
  function automatic logic [1:0] dgt_idx(input logic [3:0] d);
    logic [1:0] i;
    case (d)
      4'b1101: i = 2'd1;
      4'b1011: i = 2'd2;
      4'b0111: i = 2'd3;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/sseg2bcd.sv
// Combinational seven-segment to BCD decoder.
//   seg   : active-low pattern {g,f,e,d,c,b,a}
//   bcd   : decoded digit 0-9, DIGIT_BAD for any other pattern
//   valid : high when seg is one of the ten digit codes
module sseg2bcd
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       valid
);

  always_comb begin
    bcd   = DIGIT_BAD;
    valid = 1'b1;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Receive-side monitor for a multiplexed seven-segment display.
// Waits for each digit strobe to hold steady for SETTLE samples, decodes the
// pattern, and publishes a four-digit HH:MM frame once every slot is seen.
//   clock, reset_n : clock, async active-low reset
//   sseg           : active-low segments {g..a}
//   dgt            : active-low one-hot digit select (bit0 = min1, bit3 = hour10)
//   digits         : {hour10, hour1, min10, min1} BCD of last frame
//   frame_valid    : one-cycle pulse on publish
//   frame_err      : some digit of the published frame failed to decode
//   changed        : published frame differs from the previous one
//   stale          : no capture for TIMEOUT cycles
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  sseg,
  input  logic [3:0]  dgt,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        changed,
  output logic        stale
);

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [21:0] IDLE_MAX    = 22'(TIMEOUT);
  localparam logic [21:0] IDLE_HIT    = 22'(TIMEOUT - 1);

  // Sample history and settle FSM
  logic [6:0]  prev_sseg;
  logic [3:0]  prev_dgt;
  scan_state_e state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        capture;
  logic        same, qual;
  logic [1:0]  idx;

  // Frame assembly
  logic [3:0][3:0] slot;
  logic [3:0]      seen, seen_nx;
  logic            err_acc, err_acc_nx;
  logic            have_prev;
  logic [21:0]     idle;
  logic            timeout_hit;
  logic            publish;

  logic [3:0] bcd;
  logic       seg_ok;

  sseg2bcd u_dec (
    .seg   (sseg),
    .bcd   (bcd),
    .valid (seg_ok)
  );

  assign same = (sseg == prev_sseg) && (dgt == prev_dgt);
  assign qual = dgt_qual(dgt);
  assign idx  = dgt_idx(dgt);

  // Count restarts at 1 on any change: the differing sample is itself the
  // first sample of a new stable interval.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      ST_WAIT: begin
        if (qual) begin
          state_nx = ST_SETTLE;
          cnt_nx   = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!same) begin
          state_nx = qual ? ST_SETTLE : ST_WAIT;
          cnt_nx   = qual ? 8'd1 : 8'd0;
        end else if (cnt == SETTLE_LAST) begin
          state_nx = ST_HELD;
          cnt_nx   = 8'd0;
          capture  = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      ST_HELD: begin
        if (!same) begin
          state_nx = qual ? ST_SETTLE : ST_WAIT;
          cnt_nx   = qual ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_nx = ST_WAIT;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_WAIT;
      cnt       <= 8'd0;
      prev_sseg <= SEG_BLANK;
      prev_dgt  <= 4'hF;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      prev_sseg <= sseg;
      prev_dgt  <= dgt;
    end
  end

  // A capture on the same edge beats the timeout.
  assign timeout_hit = !capture && (idle == IDLE_HIT);
  assign publish     = (seen == 4'hF);

  // Publish/timeout clear first, then a capture on the same edge re-marks its slot.
  always_comb begin
    seen_nx    = seen;
    err_acc_nx = err_acc;
    if (publish || timeout_hit) begin
      seen_nx    = 4'h0;
      err_acc_nx = 1'b0;
    end
    if (capture) begin
      seen_nx[idx] = 1'b1;
      if (!seg_ok) err_acc_nx = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot        <= '0;
      seen        <= 4'h0;
      err_acc     <= 1'b0;
      idle        <= 22'd0;
      have_prev   <= 1'b0;
      digits      <= 16'h0000;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      changed     <= 1'b0;
      stale       <= 1'b0;
    end else begin
      seen        <= seen_nx;
      err_acc     <= err_acc_nx;
      frame_valid <= 1'b0;

      if (capture) begin
        slot[idx] <= bcd;
        idle      <= 22'd0;
        stale     <= 1'b0;
      end else if (idle != IDLE_MAX) begin
        idle <= idle + 22'd1;
      end

      if (timeout_hit) stale <= 1'b1;

      if (publish) begin
        digits      <= slot;
        frame_valid <= 1'b1;
        frame_err   <= err_acc;
        changed     <= !have_prev || (slot != digits);
        have_prev   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
module tb_sseg_scan_decoder;
  import sseg_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [6:0]  sseg;
  logic [3:0]  dgt;
  logic [15:0] digits;
  logic        frame_valid, frame_err, changed, stale;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
    logic        c;
  } frm_t;

  frm_t q[$];
  int   total  = 0;
  int   passed = 0;

  sseg_scan_decoder #(.SETTLE(4), .TIMEOUT(50)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sseg        (sseg),
    .dgt         (dgt),
    .digits      (digits),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .changed     (changed),
    .stale       (stale)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every published frame must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && frame_valid === 1'b1) begin
      chk("frame_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        frm_t f;
        f = q.pop_front();
        chk("digits",    32'(digits),    32'(f.d));
        chk("frame_err", 32'(frame_err), 32'(f.e));
        chk("changed",   32'(changed),   32'(f.c));
      end
    end
  end

  // Called at a negedge; holds the inputs for n sampling edges.
  task automatic put(input logic [3:0] d, input logic [6:0] s, input int n);
    dgt  = d;
    sseg = s;
    repeat (n) @(negedge clock);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    put(4'b1110, s0, 10);
    put(4'b1101, s1, 10);
    put(4'b1011, s2, 10);
    put(4'b0111, s3, 10);
  endtask

  task automatic drain(input string tag);
    put(4'hF, SEG_BLANK, 3);
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    dgt     = 4'hF;
    sseg    = SEG_BLANK;
    #1;
    chk("rst_digits", 32'(digits),      32'd0);
    chk("rst_fv",     32'(frame_valid), 32'd0);
    chk("rst_err",    32'(frame_err),   32'd0);
    chk("rst_chg",    32'(changed),     32'd0);
    chk("rst_stale",  32'(stale),       32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: basic frame
    q.push_back('{16'h1234, 1'b0, 1'b1});
    scan(SEG_4, SEG_3, SEG_2, SEG_1);
    drain("t1_pending");

    // 2: identical frame, then min1 change
    q.push_back('{16'h1234, 1'b0, 1'b0});
    scan(SEG_4, SEG_3, SEG_2, SEG_1);
    drain("t2a_pending");
    q.push_back('{16'h1235, 1'b0, 1'b1});
    scan(SEG_5, SEG_3, SEG_2, SEG_1);
    drain("t2b_pending");

    // 3: short glitches after a capture must not overwrite; bad code -> F;
    //    slot 3 held exactly SETTLE cycles still captures.
    q.push_back('{16'h1F36, 1'b1, 1'b1});
    put(4'b1110, SEG_6, 10);
    put(4'b1110, SEG_7, 2);
    put(4'b1110, SEG_1, 3);
    put(4'b1101, SEG_3, 10);
    put(4'b1011, 7'b0110110, 10);
    put(4'b0111, SEG_1, 4);
    drain("t3_pending");

    // 4: partial frame then idle -> stale at exactly 50 cycles after capture
    put(4'b1110, SEG_9, 10);
    put(4'b1101, SEG_9, 10);
    put(4'hF, SEG_BLANK, 43);
    chk("t4_stale_early", 32'(stale), 32'd0);
    put(4'hF, SEG_BLANK, 1);
    chk("t4_stale_set", 32'(stale), 32'd1);
    put(4'hF, SEG_BLANK, 5);
    chk("t4_no_frame", 32'(q.size()), 32'd0);
    // Resume out of order; stale partial slots must not complete a frame.
    q.push_back('{16'h1234, 1'b0, 1'b1});
    put(4'b1011, SEG_2, 3);
    chk("t4_stale_hold", 32'(stale), 32'd1);
    put(4'b1011, SEG_2, 1);
    chk("t4_stale_clr", 32'(stale), 32'd0);
    put(4'b1011, SEG_2, 6);
    put(4'b0111, SEG_1, 10);
    put(4'b1110, SEG_4, 10);
    put(4'b1101, SEG_3, 10);
    drain("t4_pending");

    // 5: two strobes at once never qualifies
    put(4'b1100, SEG_8, 100);
    chk("t5_no_frame", 32'(q.size()), 32'd0);
    chk("t5_stale", 32'(stale), 32'd1);
    put(4'hF, SEG_BLANK, 2);

    // 6: async reset mid-frame, then an all-zero frame still reports changed
    put(4'b1110, SEG_9, 10);
    put(4'b1101, SEG_3, 3);
    #3;
    chk("t6_pre_digits", 32'(digits), 32'h1234);
    reset_n = 1'b0;
    #1;
    chk("t6_digits", 32'(digits),      32'd0);
    chk("t6_fv",     32'(frame_valid), 32'd0);
    chk("t6_err",    32'(frame_err),   32'd0);
    chk("t6_chg",    32'(changed),     32'd0);
    chk("t6_stale",  32'(stale),       32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    put(4'hF, SEG_BLANK, 2);
    q.push_back('{16'h0000, 1'b0, 1'b1});
    put(4'b1101, SEG_0, 10);
    put(4'b1011, SEG_0, 10);
    put(4'b0111, SEG_0, 10);
    put(4'b1110, SEG_0, 10);
    drain("t6_pending");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
